// File: rtl/alu.sv
// Registered scalar ALU: wrapping integer add/sub, bitwise logic and shifts.
// Define ALU_FIXED_POINT_EN to add saturating Q(W/2).(W/2) FXADD/FXSUB/FXMUL.
module alu #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [4:0]            opcode,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [4:0] {
        OP_ADD   = 5'b00000,
        OP_SUB   = 5'b00001,
        OP_AND   = 5'b00010,
        OP_OR    = 5'b00011,
        OP_XOR   = 5'b00100,
        OP_SLL   = 5'b00101,
        OP_SRL   = 5'b00110,
        OP_SRA   = 5'b00111,
        OP_FXADD = 5'b01000,
        OP_FXSUB = 5'b01001,
        OP_FXMUL = 5'b01010
    } op_e;

    logic [W-1:0]   result_d;
    logic [W-1:0]   result_q;
    logic [SHW-1:0] shamt;
    logic           unused_cfg;

    // NUM_LANES only exists so vector users can share the parameter list.
    assign unused_cfg = (NUM_LANES >= 1);
    assign shamt      = operand2[SHW-1:0];

`ifdef ALU_FIXED_POINT_EN
    localparam logic [W-1:0] FX_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] FX_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0]            fx_sum;
    logic [W:0]            fx_dif;
    logic signed [2*W-1:0] fx_a;
    logic signed [2*W-1:0] fx_b;
    logic signed [2*W-1:0] fx_prod;
    logic signed [2*W-1:0] fx_shift;
    logic [W-1:0]          fx_add_sat;
    logic [W-1:0]          fx_sub_sat;
    logic [W-1:0]          fx_mul_sat;

    // One guard bit catches overflow: top two bits disagree when out of range.
    assign fx_sum = {operand1[W-1], operand1} + {operand2[W-1], operand2};
    assign fx_dif = {operand1[W-1], operand1} - {operand2[W-1], operand2};

    assign fx_add_sat = (fx_sum[W] != fx_sum[W-1]) ? (fx_sum[W] ? FX_MIN : FX_MAX)
                                                   : fx_sum[W-1:0];
    assign fx_sub_sat = (fx_dif[W] != fx_dif[W-1]) ? (fx_dif[W] ? FX_MIN : FX_MAX)
                                                   : fx_dif[W-1:0];

    assign fx_a     = {{W{operand1[W-1]}}, operand1};
    assign fx_b     = {{W{operand2[W-1]}}, operand2};
    assign fx_prod  = fx_a * fx_b;
    assign fx_shift = fx_prod >>> (W / 2);

    // The shifted product fits in W bits only if bits [2W-1:W-1] are all equal.
    assign fx_mul_sat = ((&fx_shift[2*W-1:W-1]) || !(|fx_shift[2*W-1:W-1]))
                        ? fx_shift[W-1:0]
                        : (fx_shift[2*W-1] ? FX_MIN : FX_MAX);
`endif

    always_comb begin
        result_d = '0;
        case (opcode)
            OP_ADD:   result_d = operand1 + operand2;
            OP_SUB:   result_d = operand1 - operand2;
            OP_AND:   result_d = operand1 & operand2;
            OP_OR:    result_d = operand1 | operand2;
            OP_XOR:   result_d = operand1 ^ operand2;
            OP_SLL:   result_d = operand1 << shamt;
            OP_SRL:   result_d = operand1 >> shamt;
            OP_SRA:   result_d = $signed(operand1) >>> shamt;
`ifdef ALU_FIXED_POINT_EN
            OP_FXADD: result_d = fx_add_sat;
            OP_FXSUB: result_d = fx_sub_sat;
            OP_FXMUL: result_d = fx_mul_sat;
`endif
            default:  result_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu at DATA_WIDTH=16: the driver queues expected results,
// a monitor pops one per clock edge; reset checks are made directly.
module tb_alu;

    typedef struct {
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] operand1 = '0;
    logic [15:0] operand2 = '0;
    logic [4:0]  opcode = '0;
    logic [15:0] result;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu #(
        .DATA_WIDTH(16),
        .NUM_LANES (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .operand1(operand1),
        .operand2(operand2),
        .opcode  (opcode),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, got, want);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                         input logic [15:0] want, input string nm);
        exp_t e;
        operand1 = a;
        operand2 = b;
        opcode   = op;
        e.val    = want;
        e.name   = nm;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                         input logic [15:0] want, input string nm);
        @(negedge clk);
        drive(a, b, op, want, nm);
    endtask

    // Monitor: every edge consumes the op queued in the preceding half cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, result, e.val);
            end
        end
    end

    initial begin
        logic [15:0] fx_on;
        fx_on = 16'hFFFF;
`ifndef ALU_FIXED_POINT_EN
        fx_on = 16'h0000;
`endif
        #1 rst = 1'b1;
        #1 check("reset_state", result, 16'h0000);
        repeat (2) @(posedge clk);

        @(negedge clk);
        rst = 1'b0;
        drive(16'h0002, 16'h4001, 5'b00000, 16'h4003, "add");
        apply(16'hFFFF, 16'h0002, 5'b00000, 16'h0001, "add_wrap");
        apply(16'h000A, 16'h0001, 5'b00001, 16'h0009, "sub");
        apply(16'h0000, 16'h0001, 5'b00001, 16'hFFFF, "sub_wrap");
        apply(16'hF0F0, 16'h0FF0, 5'b00010, 16'h00F0, "and");
        apply(16'hF0F0, 16'h0FF0, 5'b00011, 16'hFFF0, "or");
        apply(16'hF0F0, 16'h0FF0, 5'b00100, 16'hFF00, "xor");
        apply(16'h0001, 16'h0004, 5'b00101, 16'h0010, "sll");
        apply(16'h0001, 16'h0013, 5'b00101, 16'h0008, "sll_amt_mask");
        apply(16'h8000, 16'h0004, 5'b00110, 16'h0800, "srl");
        apply(16'h8000, 16'h0004, 5'b00111, 16'hF800, "sra_neg");
        apply(16'h7000, 16'h0004, 5'b00111, 16'h0700, "sra_pos");
        apply(16'h8001, 16'h000F, 5'b00111, 16'hFFFF, "sra_max");
        apply(16'h1234, 16'h5678, 5'b11111, 16'h0000, "undef_1f");
        apply(16'h1234, 16'h5678, 5'b01011, 16'h0000, "undef_0b");

        apply(16'h0A80, 16'h01C0, 5'b01000, 16'h0C40 & fx_on, "fxadd");
        apply(16'h7F00, 16'h0200, 5'b01000, 16'h7FFF & fx_on, "fxadd_satpos");
        apply(16'h8100, 16'hFE00, 5'b01000, 16'h8000 & fx_on, "fxadd_satneg");
        apply(16'h0300, 16'h0100, 5'b01001, 16'h0200 & fx_on, "fxsub");
        apply(16'h8000, 16'h0001, 5'b01001, 16'h8000 & fx_on, "fxsub_satneg");
        apply(16'h7FFF, 16'hFFFF, 5'b01001, 16'h7FFF & fx_on, "fxsub_satpos");
        apply(16'h0180, 16'h0200, 5'b01010, 16'h0300 & fx_on, "fxmul");
        apply(16'h4000, 16'h0400, 5'b01010, 16'h7FFF & fx_on, "fxmul_satpos");
        apply(16'h8000, 16'h0200, 5'b01010, 16'h8000 & fx_on, "fxmul_satneg");
        apply(16'hFFFF, 16'h0080, 5'b01010, 16'hFFFF & fx_on, "fxmul_floor");

        // Mid-cycle input changes must not disturb the registered result.
        apply(16'h1111, 16'h2222, 5'b00000, 16'h3333, "add_hold_a");
        @(posedge clk);
        #3;
        operand1 = 16'hDEAD;
        opcode   = 5'b00100;
        #1 check("hold_between_edges", result, 16'h3333);

        apply(16'h1234, 16'h0001, 5'b00000, 16'h1235, "add_pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1 check("rst_async", result, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 check("rst_hold", result, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(16'h0005, 16'h0006, 5'b00000, 16'h000B, "first_after_rst");
        apply(16'h00FF, 16'h0F0F, 5'b00100, 16'h0FF0, "xor_after_rst");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
